// File: rtl/apu_pkg.sv
// Shared types and constants for the APU envelope/volume path.
package apu_pkg;

    typedef struct packed {
        logic [3:0] vol;
        logic [2:0] timer;   // 3'b000 encodes a count of 8
        logic       running;
    } env_state_t;

    localparam logic [3:0] ENV_VOL_MAX = 4'hF;

    typedef enum logic [1:0] {
        WAVE_LVL_MUTE    = 2'd0,
        WAVE_LVL_FULL    = 2'd1,
        WAVE_LVL_HALF    = 2'd2,
        WAVE_LVL_QUARTER = 2'd3
    } wave_lvl_t;

    function automatic logic [3:0] wave_scale(input logic [3:0] sample, input wave_lvl_t lvl);
        logic [3:0] res;
        res = '0;
        case (lvl)
            WAVE_LVL_MUTE:    res = '0;
            WAVE_LVL_FULL:    res = sample;
            WAVE_LVL_HALF:    res = sample >> 1;
            WAVE_LVL_QUARTER: res = sample >> 2;
            default:          res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/envelope_gen_if.sv
// Control/config inputs and packed amplitude output of the envelope generator.
interface envelope_gen_if;
    logic        env_tick;
    logic [2:0]  trig;
    logic [7:0]  nr12;
    logic [7:0]  nr22;
    logic [7:0]  nr42;
    logic [2:0]  ch_on;
    logic [3:0]  wave_sample;
    logic [1:0]  wave_level;
    logic        wave_on;
    logic [15:0] volumes_raw;

    modport master (
        output env_tick, trig, nr12, nr22, nr42, ch_on,
               wave_sample, wave_level, wave_on,
        input  volumes_raw
    );

    modport slave (
        input  env_tick, trig, nr12, nr22, nr42, ch_on,
               wave_sample, wave_level, wave_on,
        output volumes_raw
    );
endinterface

// File: rtl/envelope_channel.sv
// One volume-envelope engine: trigger load, 64 Hz stepping with saturation,
// and a registered output nibble gated by channel enable and DAC power.
module envelope_channel (
    input  logic       clk,
    input  logic       reset,
    input  logic       trig,
    input  logic       tick,
    input  logic [7:0] nrx2,
    input  logic       ch_on,
    output logic [3:0] vol_out
);
    import apu_pkg::*;

    env_state_t st;
    env_state_t st_next;
    logic [2:0] period;
    logic [2:0] timer_dec;
    logic       dir_up;
    logic       dac_on;

    assign period = nrx2[2:0];
    assign dir_up = nrx2[3];
    assign dac_on = (nrx2[7:3] != 5'd0);

    always_comb begin
        st_next   = st;
        timer_dec = (st.timer == 3'd0) ? 3'd7 : (st.timer - 3'd1);

        if (trig) begin
            st_next.vol     = nrx2[7:4];
            st_next.timer   = period;
            st_next.running = 1'b1;
        end else if (tick && (period != 3'd0)) begin
            st_next.timer = timer_dec;
            if (timer_dec == 3'd0) begin
                st_next.timer = period;
                if (st.running) begin
                    if (dir_up) begin
                        if (st.vol != ENV_VOL_MAX) st_next.vol = st.vol + 4'd1;
                        else                       st_next.running = 1'b0;
                    end else begin
                        if (st.vol != 4'd0) st_next.vol = st.vol - 4'd1;
                        else                st_next.running = 1'b0;
                    end
                end
            end
        end
    end

    // Output is taken from the next-state volume so a trigger or step shows
    // up one edge later rather than two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= '0;
            vol_out <= '0;
        end else begin
            st      <= st_next;
            vol_out <= (ch_on && dac_on) ? st_next.vol : '0;
        end
    end

endmodule

// File: rtl/envelope_gen.sv
// Per-channel APU amplitudes: three envelope engines plus the registered
// pattern-channel level shifter, packed as {noise, pattern, pulse2, pulse1}.
module envelope_gen (
    input  logic           clk,
    input  logic           reset,
    envelope_gen_if.slave  bus
);
    import apu_pkg::*;

    logic [3:0] p1_vol;
    logic [3:0] p2_vol;
    logic [3:0] noise_vol;
    logic [3:0] wave_nib;

    envelope_channel u_pulse1 (
        .clk     (clk),
        .reset   (reset),
        .trig    (bus.trig[0]),
        .tick    (bus.env_tick),
        .nrx2    (bus.nr12),
        .ch_on   (bus.ch_on[0]),
        .vol_out (p1_vol)
    );

    envelope_channel u_pulse2 (
        .clk     (clk),
        .reset   (reset),
        .trig    (bus.trig[1]),
        .tick    (bus.env_tick),
        .nrx2    (bus.nr22),
        .ch_on   (bus.ch_on[1]),
        .vol_out (p2_vol)
    );

    envelope_channel u_noise (
        .clk     (clk),
        .reset   (reset),
        .trig    (bus.trig[2]),
        .tick    (bus.env_tick),
        .nrx2    (bus.nr42),
        .ch_on   (bus.ch_on[2]),
        .vol_out (noise_vol)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wave_nib <= '0;
        end else begin
            wave_nib <= bus.wave_on ? wave_scale(bus.wave_sample, wave_lvl_t'(bus.wave_level)) : '0;
        end
    end

    assign bus.volumes_raw = {noise_vol, wave_nib, p2_vol, p1_vol};

endmodule

// File: tb/tb_envelope_gen.sv
// Scoreboard bench for envelope_gen: directed scenarios plus random traffic
// against a tick-counting reference model.
module tb_envelope_gen;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    envelope_gen_if bus();

    envelope_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    // reference model: volume, ticks remaining until next step, running flag
    int m_vol[3];
    int m_left[3];
    bit m_run[3];

    logic [7:0] cur_nr[3];
    logic [2:0] cur_ch_on;
    logic [3:0] cur_ws;
    logic [1:0] cur_wl;
    logic       cur_won;

    task automatic model_step(input logic [2:0] t, input logic tk, input logic r,
                              output logic [15:0] e);
        int per;
        int w;
        int pos[3];
        pos[0] = 0; pos[1] = 4; pos[2] = 12;
        e = '0;
        if (r) begin
            for (int ch = 0; ch < 3; ch++) begin
                m_vol[ch] = 0; m_left[ch] = 8; m_run[ch] = 1'b0;
            end
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                per = int'(cur_nr[ch][2:0]);
                if (t[ch]) begin
                    m_vol[ch]  = int'(cur_nr[ch][7:4]);
                    m_left[ch] = (per == 0) ? 8 : per;
                    m_run[ch]  = 1'b1;
                end else if (tk && per != 0) begin
                    m_left[ch] = m_left[ch] - 1;
                    if (m_left[ch] == 0) begin
                        m_left[ch] = per;
                        if (m_run[ch]) begin
                            if (cur_nr[ch][3]) begin
                                if (m_vol[ch] < 15) m_vol[ch] = m_vol[ch] + 1;
                                else                m_run[ch] = 1'b0;
                            end else begin
                                if (m_vol[ch] > 0) m_vol[ch] = m_vol[ch] - 1;
                                else               m_run[ch] = 1'b0;
                            end
                        end
                    end
                end
                if (cur_ch_on[ch] && cur_nr[ch][7:3] != 5'd0)
                    e[pos[ch] +: 4] = 4'(m_vol[ch]);
            end
            w = 0;
            if (cur_won) begin
                case (cur_wl)
                    2'd1: w = int'(cur_ws);
                    2'd2: w = int'(cur_ws) / 2;
                    2'd3: w = int'(cur_ws) / 4;
                    default: w = 0;
                endcase
            end
            e[11:8] = 4'(w);
        end
    endtask

    task automatic drive(input logic [2:0] t, input logic tk, input logic r);
        logic [15:0] e;
        @(negedge clk);
        reset           = r;
        bus.trig        = t;
        bus.env_tick    = tk;
        bus.nr12        = cur_nr[0];
        bus.nr22        = cur_nr[1];
        bus.nr42        = cur_nr[2];
        bus.ch_on       = cur_ch_on;
        bus.wave_sample = cur_ws;
        bus.wave_level  = cur_wl;
        bus.wave_on     = cur_won;
        model_step(t, tk, r, e);
        exp_q.push_back(e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(3'b000, 1'b1, 1'b0);
            drive(3'b000, 1'b0, 1'b0);
        end
    endtask

    // must directly follow a drive(): samples the edge that drive() set up
    task automatic check_nib(input string name, input int idx, input logic [3:0] want);
        logic [3:0] got;
        @(posedge clk);
        #2;
        got = bus.volumes_raw[idx*4 +: 4];
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // scoreboard monitor
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.volumes_raw !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: got %h expected %h", $time, bus.volumes_raw, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] wtab[4];
        logic [2:0] t;
        logic       tk;
        logic       r;
        wtab[0] = 4'd0; wtab[1] = 4'd11; wtab[2] = 4'd5; wtab[3] = 4'd2;

        reset = 1'b1;
        bus.trig = '0; bus.env_tick = 1'b0;
        bus.nr12 = '0; bus.nr22 = '0; bus.nr42 = '0; bus.ch_on = '0;
        bus.wave_sample = '0; bus.wave_level = '0; bus.wave_on = 1'b0;
        for (int ch = 0; ch < 3; ch++) cur_nr[ch] = '0;
        cur_ch_on = '0; cur_ws = '0; cur_wl = '0; cur_won = 1'b0;

        drive(3'b000, 1'b0, 1'b1);
        check_nib("reset_p1", 0, 4'd0);
        drive(3'b000, 1'b0, 1'b0);
        check_nib("idle_after_reset", 0, 4'd0);

        // pulse1 decay from 15, period 3
        cur_ch_on = 3'b111;
        cur_nr[0] = 8'hF3;
        drive(3'b001, 1'b0, 1'b0);
        check_nib("p1_trig", 0, 4'd15);
        ticks(3);
        check_nib("p1_3ticks", 0, 4'd14);
        ticks(42);
        check_nib("p1_45ticks", 0, 4'd0);
        ticks(5);
        check_nib("p1_floor", 0, 4'd0);

        // pulse2 rise from 0, period 2
        cur_nr[1] = 8'h0A;
        drive(3'b010, 1'b0, 1'b0);
        check_nib("p2_trig", 1, 4'd0);
        ticks(2);
        check_nib("p2_2ticks", 1, 4'd1);
        ticks(28);
        check_nib("p2_30ticks", 1, 4'd15);
        ticks(2);
        check_nib("p2_32ticks", 1, 4'd15);

        // noise with period 0, then DAC off
        cur_nr[2] = 8'h70;
        drive(3'b100, 1'b0, 1'b0);
        check_nib("noise_trig", 3, 4'd7);
        ticks(20);
        check_nib("noise_hold", 3, 4'd7);
        cur_nr[2] = 8'h07;
        drive(3'b000, 1'b0, 1'b0);
        check_nib("noise_dac_off", 3, 4'd0);

        // trigger beats a coincident tick
        cur_nr[0] = 8'h51;
        drive(3'b001, 1'b1, 1'b0);
        check_nib("p1_trig_tick", 0, 4'd5);
        ticks(1);
        check_nib("p1_next_tick", 0, 4'd4);

        // pattern level shifter
        cur_ws = 4'hB;
        cur_won = 1'b1;
        for (int lv = 0; lv < 4; lv++) begin
            cur_wl = 2'(lv);
            drive(3'b000, 1'b0, 1'b0);
            check_nib("wave_level", 2, wtab[lv]);
        end
        cur_won = 1'b0;
        drive(3'b000, 1'b0, 1'b0);
        check_nib("wave_off", 2, 4'd0);

        // asynchronous reset mid-run
        cur_nr[0] = 8'h90;
        drive(3'b001, 1'b0, 1'b0);
        check_nib("p1_vol9", 0, 4'd9);
        @(negedge clk);
        bus.trig = '0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus.volumes_raw !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async: got %h expected 0000", bus.volumes_raw);
        end
        drive(3'b000, 1'b0, 1'b1);
        drive(3'b000, 1'b0, 1'b0);
        ticks(3);
        check_nib("silent_after_reset", 0, 4'd0);
        drive(3'b001, 1'b0, 1'b0);
        check_nib("p1_retrig", 0, 4'd9);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            for (int ch = 0; ch < 3; ch++)
                if ($urandom_range(0, 31) == 0) cur_nr[ch] = 8'($urandom);
            if ($urandom_range(0, 15) == 0) cur_ch_on = 3'($urandom);
            cur_ws  = 4'($urandom);
            cur_wl  = 2'($urandom);
            cur_won = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < 3; b++) t[b] = ($urandom_range(0, 15) == 0);
            tk = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 499) == 0);
            drive(t, tk, r);
        end

        drive(3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
